// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM state type and lane/alignment helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    // Byte-lane mask for a transfer of the given size starting at lane 0.
    function automatic logic [7:0] size_lanes(input logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 8'h01;
            HSIZE_HALF: return 8'h03;
            HSIZE_WORD: return 8'h0F;
            default:    return 8'hFF;
        endcase
    endfunction

    // Address LSBs that must be zero for a transfer of the given size.
    function automatic logic [2:0] align_mask(input logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 3'b000;
            HSIZE_HALF: return 3'b001;
            HSIZE_WORD: return 3'b011;
            default:    return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Byte-enabled RAM: synchronous write, asynchronous read. Contents have no reset.
//   clk_i      clock
//   we_i       write enable
//   be_i       byte enables, little-endian lanes
//   waddr_i    write word index
//   wdata_i    write data
//   raddr_i    read word index
//   rdata_c_o  combinational read data
module ahb_mem_array #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic                                       clk_i,
    input  logic                                       we_i,
    input  logic [DATA_W/8-1:0]                        be_i,
    input  logic [$clog2(MEM_BYTES/(DATA_W/8))-1:0]    waddr_i,
    input  logic [DATA_W-1:0]                          wdata_i,
    input  logic [$clog2(MEM_BYTES/(DATA_W/8))-1:0]    raddr_i,
    output logic [DATA_W-1:0]                          rdata_c_o
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned WORDS  = MEM_BYTES / NBYTES;

    logic [DATA_W-1:0] mem_q [WORDS];

    // Per-lane write; unselected lanes keep their contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave with configurable wait states and two-cycle ERROR response.
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   HSEL_i    slave select
//   HADDR_i   byte address
//   HTRANS_i  transfer type
//   HSIZE_i   transfer size
//   HWRITE_i  write/read
//   HWDATA_i  write data (data phase)
//   HREADY_o  transfer done, also the HREADY this slave samples
//   HRESP_o   OKAY / ERROR
//   HRDATA_o  read data, zero unless an OKAY read completes
module ahb_mem_slave import ahb_pkg::*; #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_BYTES   = 65536,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              HSEL_i,
    input  logic [ADDR_W-1:0] HADDR_i,
    input  logic [1:0]        HTRANS_i,
    input  logic [2:0]        HSIZE_i,
    input  logic              HWRITE_i,
    input  logic [DATA_W-1:0] HWDATA_i,
    output logic              HREADY_o,
    output logic [1:0]        HRESP_o,
    output logic [DATA_W-1:0] HRDATA_o
);

    localparam int unsigned NBYTES  = DATA_W / 8;
    localparam int unsigned LANE_AW = $clog2(NBYTES);
    localparam int unsigned MEM_AW  = $clog2(MEM_BYTES);
    localparam int unsigned WORD_AW = MEM_AW - LANE_AW;

    slv_state_e          state_q, state_d;
    logic [2:0]          wcnt_q, wcnt_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic                write_q, write_d;
    logic                dphase_q, dphase_d;
    logic                hready_q, hready_d;
    logic [1:0]          hresp_q, hresp_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;

    logic                accept_c;
    logic                err_c;
    logic                we_c;
    logic [NBYTES-1:0]   be_c;
    logic [DATA_W-1:0]   bmask_c;
    logic [WORD_AW-1:0]  wr_word_c;
    logic [WORD_AW-1:0]  rd_word_c;
    logic [DATA_W-1:0]   mem_rdata_c;
    logic [DATA_W-1:0]   rd_merged_c;

    // Address-phase qualification and error classification.
    assign accept_c = hready_q && HSEL_i &&
                      (HTRANS_i == HTRANS_NONSEQ || HTRANS_i == HTRANS_SEQ);
    assign err_c    = (64'(HADDR_i) >= 64'(MEM_BYTES)) ||
                      (HSIZE_i > 3'(LANE_AW)) ||
                      (|(HADDR_i[2:0] & align_mask(HSIZE_i)));

    // An OKAY write commits at the end of its completing (IDLE, HREADY=1) cycle.
    assign we_c      = (state_q == ST_IDLE) && dphase_q && write_q && !rst_i;
    assign be_c      = NBYTES'(size_lanes(size_q) << addr_q[LANE_AW-1:0]);
    assign wr_word_c = addr_q[MEM_AW-1:LANE_AW];

    always_comb begin
        bmask_c = '0;
        for (int b = 0; b < int'(NBYTES); b++) begin
            bmask_c[8*b +: 8] = {8{be_c[b]}};
        end
    end

    // Zero-wait reads look up the address being accepted; waited reads use the registered one.
    assign rd_word_c = (state_q == ST_WAIT) ? addr_q[MEM_AW-1:LANE_AW]
                                            : HADDR_i[MEM_AW-1:LANE_AW];

    // Forward the write committing this edge into an overlapping read of the same word.
    assign rd_merged_c = (we_c && (wr_word_c == rd_word_c))
                       ? ((mem_rdata_c & ~bmask_c) | (HWDATA_i & bmask_c))
                       : mem_rdata_c;

    ahb_mem_array #(
        .DATA_W    (DATA_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk_i     (clk_i),
        .we_i      (we_c),
        .be_i      (be_c),
        .waddr_i   (wr_word_c),
        .wdata_i   (HWDATA_i),
        .raddr_i   (rd_word_c),
        .rdata_c_o (mem_rdata_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        dphase_d = dphase_q;

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d  = ST_IDLE;
                dphase_d = 1'b0;
                if (accept_c) begin
                    addr_d  = HADDR_i[MEM_AW-1:0];
                    size_d  = HSIZE_i;
                    write_d = HWRITE_i;
                    if (err_c) begin
                        state_d = ST_ERR1;
                    end else begin
                        dphase_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            wcnt_d  = 3'(WAIT_STATES - 1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hready_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        hrdata_d = ((state_d == ST_IDLE) && dphase_d && !write_d) ? rd_merged_c : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 3'd0;
            addr_q   <= '0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            dphase_q <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            dphase_q <= dphase_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign HREADY_o = hready_q;
    assign HRESP_o  = hresp_q;
    assign HRDATA_o = hrdata_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: three slave instances (32b/0 waits, 32b/3 waits, 64b/0 waits) on a shared bus.
module tb_ahb_mem_slave;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    int          cur;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [63:0] hwdata;

    logic        hs0, hs3, hs64;
    logic        hr0, hr3, hr64;
    logic [1:0]  rs0, rs3, rs64;
    logic [31:0] rd0, rd3;
    logic [63:0] rd64;

    logic        hready;
    logic [1:0]  hresp;
    logic [63:0] hrdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign hs0  = sel && (cur == 0);
    assign hs3  = sel && (cur == 1);
    assign hs64 = sel && (cur == 2);

    always_comb begin
        case (cur)
            0:       begin hready = hr0;  hresp = rs0;  hrdata = 64'(rd0); end
            1:       begin hready = hr3;  hresp = rs3;  hrdata = 64'(rd3); end
            default: begin hready = hr64; hresp = rs64; hrdata = rd64;     end
        endcase
    end

    ahb_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(1024), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .HSEL_i(hs0), .HADDR_i(haddr), .HTRANS_i(htrans),
        .HSIZE_i(hsize), .HWRITE_i(hwrite), .HWDATA_i(hwdata[31:0]),
        .HREADY_o(hr0), .HRESP_o(rs0), .HRDATA_o(rd0));

    ahb_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(1024), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .HSEL_i(hs3), .HADDR_i(haddr), .HTRANS_i(htrans),
        .HSIZE_i(hsize), .HWRITE_i(hwrite), .HWDATA_i(hwdata[31:0]),
        .HREADY_o(hr3), .HRESP_o(rs3), .HRDATA_o(rd3));

    ahb_mem_slave #(.DATA_W(64), .ADDR_W(32), .MEM_BYTES(1024), .WAIT_STATES(0)) dut64 (
        .clk_i(clk), .rst_i(rst), .HSEL_i(hs64), .HADDR_i(haddr), .HTRANS_i(htrans),
        .HSIZE_i(hsize), .HWRITE_i(hwrite), .HWDATA_i(hwdata),
        .HREADY_o(hr64), .HRESP_o(rs64), .HRDATA_o(rd64));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic use_dut(input int n);
        cur = n;
        #1;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic [31:0] a,
                              input logic [2:0] sz, input logic wr);
        sel    = 1'b1;
        htrans = tr;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
    endtask

    task automatic bus_idle();
        sel    = 1'b0;
        htrans = T_IDLE;
        hwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d);
        int n;
        addr_phase(T_NONSEQ, a, sz, 1'b1);
        cyc();
        bus_idle();
        hwdata = d;
        n = 0;
        while (!hready && n < 16) begin
            n++;
            cyc();
        end
        chk("wr_ready", 64'(hready), 64'd1);
        cyc();
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz,
                      output logic [63:0] d, output int waits);
        int n;
        addr_phase(T_NONSEQ, a, sz, 1'b0);
        cyc();
        bus_idle();
        n = 0;
        while (!hready && n < 16) begin
            n++;
            cyc();
        end
        chk("rd_ready", 64'(hready), 64'd1);
        d     = hrdata;
        waits = n;
        cyc();
    endtask

    task automatic err_xfer(input string tag, input logic [31:0] a,
                            input logic [2:0] sz, input logic wr_en);
        addr_phase(T_NONSEQ, a, sz, wr_en);
        cyc();
        chk({tag, "_err1_ready"}, 64'(hready), 64'd0);
        chk({tag, "_err1_resp"},  64'(hresp),  64'd1);
        bus_idle();
        hwdata = '1;
        cyc();
        chk({tag, "_err2_ready"}, 64'(hready), 64'd1);
        chk({tag, "_err2_resp"},  64'(hresp),  64'd1);
        chk({tag, "_err2_rdata"}, hrdata,      64'd0);
        cyc();
        chk({tag, "_after_resp"}, 64'(hresp),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int          w;

        rst    = 1'b1;
        cur    = 0;
        hwdata = '0;
        haddr  = '0;
        hsize  = 3'd0;
        bus_idle();
        repeat (2) cyc();

        for (int i = 0; i < 3; i++) begin
            use_dut(i);
            chk("rst_ready", 64'(hready), 64'd1);
            chk("rst_resp",  64'(hresp),  64'd0);
            chk("rst_rdata", hrdata,      64'd0);
        end
        rst = 1'b0;
        cyc();

        // Zero-wait write then back-to-back read of the same word.
        use_dut(0);
        addr_phase(T_NONSEQ, 32'h10, 3'd2, 1'b1);
        cyc();
        chk("raw_wr_ready", 64'(hready), 64'd1);
        chk("raw_wr_rdata", hrdata,      64'd0);
        hwdata = 64'h0000_0000_DEAD_BEEF;
        addr_phase(T_NONSEQ, 32'h10, 3'd2, 1'b0);
        cyc();
        chk("raw_rd_ready", 64'(hready), 64'd1);
        chk("raw_rd_resp",  64'(hresp),  64'd0);
        chk("raw_rd_data",  hrdata,      64'h0000_0000_DEAD_BEEF);
        bus_idle();
        cyc();
        chk("idle_rdata", hrdata, 64'd0);

        // Byte write into lane 3 of an existing word.
        wr(32'h10, 3'd2, 64'h0000_0000_1122_3344);
        wr(32'h13, 3'd0, 64'h0000_0000_AA5A_5A5A);
        rd(32'h10, 3'd2, d, w);
        chk("byte_merge", d, 64'h0000_0000_AA22_3344);
        chk("byte_waits", 64'(w), 64'd0);
        rd(32'h13, 3'd0, d, w);
        chk("byte_read_full", d, 64'h0000_0000_AA22_3344);

        // Error responses leave memory untouched.
        wr(32'h0, 3'd2, 64'h0000_0000_0102_0304);
        err_xfer("oob",  32'h400, 3'd2, 1'b0);
        err_xfer("mis",  32'h001, 3'd1, 1'b1);
        err_xfer("size", 32'h000, 3'd3, 1'b1);
        rd(32'h0, 3'd2, d, w);
        chk("err_mem_kept", d, 64'h0000_0000_0102_0304);

        // Three wait states: four-beat incrementing read burst.
        use_dut(1);
        for (int k = 0; k < 4; k++) begin
            wr(32'h20 + 32'(4 * k), 3'd2, 64'(32'hC0DE_0000 | 32'(k)));
        end
        addr_phase(T_NONSEQ, 32'h20, 3'd2, 1'b0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                addr_phase(T_SEQ, 32'h20 + 32'(4 * (k + 1)), 3'd2, 1'b0);
            end else begin
                bus_idle();
            end
            w = 0;
            while (!hready && w < 16) begin
                w++;
                cyc();
            end
            chk("burst_waits", 64'(w), 64'd3);
            chk("burst_data",  hrdata, 64'(32'hC0DE_0000 | 32'(k)));
            cyc();
        end

        // Reset during the wait phase of a write abandons it.
        wr(32'h40, 3'd2, 64'h0000_0000_1234_5678);
        addr_phase(T_NONSEQ, 32'h40, 3'd2, 1'b1);
        cyc();
        chk("rst_mid_wait", 64'(hready), 64'd0);
        bus_idle();
        hwdata = 64'h55;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_ready", 64'(hready), 64'd1);
        chk("rst_mid_resp",  64'(hresp),  64'd0);
        chk("rst_mid_rdata", hrdata,      64'd0);
        cyc();
        chk("rst_mid_ready2", 64'(hready), 64'd1);
        rd(32'h40, 3'd2, d, w);
        chk("rst_mem_kept", d, 64'h0000_0000_1234_5678);
        chk("rst_rd_waits", 64'(w), 64'd3);

        // 64-bit bus: word write at 0x4 touches lanes 4..7 only.
        use_dut(2);
        wr(32'h0, 3'd3, 64'h1111_1111_2222_2222);
        wr(32'h4, 3'd2, 64'hCAFE_F00D_9999_9999);
        rd(32'h0, 3'd3, d, w);
        chk("w64_dword", d, 64'hCAFE_F00D_2222_2222);
        rd(32'h4, 3'd2, d, w);
        chk("w64_word_full", d, 64'hCAFE_F00D_2222_2222);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bus data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning HADDR width in bits.
REQ-003 SHALL have parameter MEM_BYTES, default 65536, meaning backing-store size in bytes; power of two and at least DATA_W/8.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning HREADY_o-low cycles inserted per OKAY data phase; range 0..7.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port HSEL_i  input  1  slave select.
REQ-008 SHALL have port HADDR_i  input  ADDR_W  byte address.
REQ-009 SHALL have port HTRANS_i  input  2  transfer type: IDLE, BUSY, NONSEQ, SEQ.
REQ-010 SHALL have port HSIZE_i  input  3  transfer size.
REQ-011 SHALL have port HWRITE_i  input  1  1 = write.
REQ-012 SHALL have port HWDATA_i  input  DATA_W  write data, data phase.
REQ-013 SHALL have port HREADY_o  output  1  transfer done; this is also the bus HREADY that the slave samples.
REQ-014 SHALL have port HRESP_o  output  2  OKAY=00 or ERROR=01.
REQ-015 SHALL have port HRDATA_o  output  DATA_W  read data.

Function
REQ-016 SHALL accept an address phase in any cycle with HREADY_o=1, HSEL_i=1 and HTRANS_i equal to NONSEQ or SEQ; it SHALL register HADDR_i, HSIZE_i and HWRITE_i in that cycle.
REQ-017 SHALL treat IDLE, BUSY or HSEL_i=0 as no transfer; the next cycle SHALL give HREADY_o=1 and HRESP_o=OKAY with no memory access.
REQ-018 SHALL flag an accepted transfer as error if any of these hold: HADDR_i >= MEM_BYTES; HSIZE_i > log2(DATA_W/8); or HADDR_i is not aligned to 2^HSIZE_i.
REQ-019 SHALL run an FSM with states IDLE, WAIT, ERR1 and ERR2.
REQ-020 SHALL make these FSM transitions: IDLE goes to WAIT on an accepted OKAY transfer with WAIT_STATES>0; IDLE goes to ERR1 on an error transfer; WAIT goes to IDLE when the counter expires; ERR1 goes to ERR2; ERR2 goes to IDLE, or straight into the next transfer accepted in ERR2.
REQ-021 SHALL hold HREADY_o=0 for exactly WAIT_STATES cycles of an OKAY data phase, then drive HREADY_o=1 for one cycle; with WAIT_STATES=0 the data phase completes in the cycle right after the address phase.
REQ-022 SHALL give an error transfer a two-cycle response: ERR1 with HREADY_o=0 and HRESP_o=ERROR, then ERR2 with HREADY_o=1 and HRESP_o=ERROR; an error write SHALL modify no memory.
REQ-023 SHALL commit a write on the clock edge ending its final data-phase cycle, using HWDATA_i from that cycle.
REQ-024 SHALL write only the byte lanes selected by the registered address LSBs and HSIZE, using little-endian lane mapping, and SHALL leave every other byte unchanged.
REQ-025 SHALL present read data in the cycle with HREADY_o=1, with the addressed word placed on the full bus width.
REQ-026 SHALL return the new data when a read's address phase overlaps the data phase of a write to the same word (read-after-write); with zero waits this back-to-back case SHALL also hold.
REQ-027 SHALL drive HRDATA_o to 0 in every cycle that is not a read completing with OKAY.
REQ-028 SHALL support back-to-back pipelined NONSEQ/SEQ transfers, incrementing or wrapping as driven by the master, with no dead cycle when WAIT_STATES=0.
REQ-029 SHALL sample the address phase of the next transfer while in the last cycle of the current data phase.
REQ-030 SHALL wrap accesses modulo MEM_BYTES for any address below MEM_BYTES; addresses at or above MEM_BYTES are errors per REQ-018.

Reset
REQ-031 SHALL, when rst_i=1 at a clock edge, set the FSM to IDLE, the wait counter to 0, HREADY_o to 1, HRESP_o to OKAY, HRDATA_o to 0 and clear all registered address-phase state.
REQ-032 SHALL abandon any in-flight transfer when reset is asserted mid-transfer; a pending write in that transfer SHALL NOT be committed.
REQ-033 SHALL NOT clear memory contents on reset.

Structure
REQ-034 SHALL take the HTRANS, HSIZE and HRESP encodings and the FSM state type from shared package ahb_pkg.
REQ-035 SHALL contain one sub-module, ahb_mem_array: a byte-enabled synchronous-write RAM with asynchronous read, parameterised by DATA_W and MEM_BYTES.

Verification
REQ-036 Bench SHALL cover: WAIT_STATES=0, write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read returns 0xDEADBEEF one cycle after its address phase, with no HREADY_o low cycle.
REQ-037 Bench SHALL cover: byte write 0xAA to 0x13 over a word containing 0x11223344 -> word reads 0xAA223344.
REQ-038 Bench SHALL cover: read at address MEM_BYTES, and halfword at 0x01 -> each gives ERR1 then ERR2 with HRESP_o=01, and memory is unchanged.
REQ-039 Bench SHALL cover: WAIT_STATES=3, four-beat INCR read from 0x20 -> each beat shows 3 cycles with HREADY_o=0 followed by 1 cycle with HREADY_o=1, and data is correct.
REQ-040 Bench SHALL cover: rst_i asserted during WAIT of a write of 0x55 to 0x40 -> next cycle is IDLE, HREADY_o=1, and 0x40 keeps its old value.
REQ-041 Bench SHALL cover: DATA_W=64, word write to 0x4 -> only byte lanes 4 to 7 change.
